// File: rtl/preg_free_list_if.sv
// Rename/commit side of the physical-register free list.
// Allocation is valid/ready: alloc_valid_o advertises alloc_preg_o, and an
// allocation completes on the clock edge where alloc_valid_o & alloc_ready_i
// are both high and restore_i is low. free_valid_i is a one-cycle command
// with no backpressure.
interface preg_free_list_if #(
  parameter int NUM_PREGS = 64
);
  localparam int IW = $clog2(NUM_PREGS);

  logic          alloc_valid_o;
  logic [IW-1:0] alloc_preg_o;
  logic          alloc_ready_i;
  logic          free_valid_i;
  logic [IW-1:0] free_preg_i;
  logic          snapshot_i;
  logic          restore_i;
  logic [IW:0]   free_count_o;
  logic          double_free_o;

  // Rename/commit logic drives the commands and consumes the offer.
  modport master (
    input  alloc_valid_o, alloc_preg_o, free_count_o, double_free_o,
    output alloc_ready_i, free_valid_i, free_preg_i, snapshot_i, restore_i
  );

  // The free list itself.
  modport slave (
    output alloc_valid_o, alloc_preg_o, free_count_o, double_free_o,
    input  alloc_ready_i, free_valid_i, free_preg_i, snapshot_i, restore_i
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical-register free list: free bitmap, MSB-first allocation,
// one branch checkpoint, sticky double-free detection.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  preg_free_list_if.slave    fl
);
  localparam int IW = $clog2(NUM_PREGS);
  localparam int CW = IW + 1;
  // Architectural pregs 0..NUM_ARCH-1 hold the identity map at reset.
  localparam logic [NUM_PREGS-1:0] RESET_MAP = {NUM_PREGS{1'b1}} << NUM_ARCH;
  localparam logic [NUM_PREGS-1:0] ONE       = {{(NUM_PREGS-1){1'b0}}, 1'b1};

  logic [NUM_PREGS-1:0] free_q, free_d;
  logic [NUM_PREGS-1:0] snap_q, snap_d;
  logic                 double_free_q, double_free_d;

  logic                 any_free;
  logic [IW-1:0]        alloc_idx;
  logic [CW-1:0]        pop_cnt;
  logic                 alloc_fire;
  logic [NUM_PREGS-1:0] alloc_onehot;
  logic [NUM_PREGS-1:0] free_onehot;

  // Priority encoder (highest set bit wins) and popcount over the registered bitmap.
  always_comb begin
    any_free  = |free_q;
    alloc_idx = '0;
    pop_cnt   = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (free_q[i]) alloc_idx = IW'(i);
      pop_cnt = pop_cnt + CW'(free_q[i]);
    end
  end

  // Next-state bitmap, checkpoint and error flag.
  always_comb begin
    alloc_fire    = any_free & fl.alloc_ready_i & ~fl.restore_i;
    alloc_onehot  = alloc_fire ? (ONE << alloc_idx) : '0;
    free_onehot   = fl.free_valid_i ? (ONE << fl.free_preg_i) : '0;
    free_d        = free_q;
    snap_d        = snap_q;
    double_free_d = double_free_q;
    if (fl.restore_i) begin
      // Recovery: checkpoint plus any concurrent free; restore beats snapshot.
      free_d = snap_q | free_onehot;
    end else begin
      // Set after clear so a same-cycle alloc+free of one index leaves it free.
      free_d = (free_q & ~alloc_onehot) | free_onehot;
      if (fl.snapshot_i) snap_d = free_d;
      if (fl.free_valid_i && free_q[fl.free_preg_i] &&
          !(alloc_fire && (alloc_idx == fl.free_preg_i)))
        double_free_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the identity-mapped list.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_q        <= RESET_MAP;
      snap_q        <= RESET_MAP;
      double_free_q <= 1'b0;
    end else begin
      free_q        <= free_d;
      snap_q        <= snap_d;
      double_free_q <= double_free_d;
    end
  end

  assign fl.alloc_valid_o = any_free;
  assign fl.alloc_preg_o  = alloc_idx;
  assign fl.free_count_o  = pop_cnt;
  assign fl.double_free_o = double_free_q;
endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list with NUM_PREGS=8, NUM_ARCH=4.
module tb_preg_free_list;
  localparam int NP = 8;
  localparam int NA = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  preg_free_list_if #(.NUM_PREGS(NP)) fl_if ();

  preg_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fl    (fl_if.slave)
  );

  // Clock: posedge every 10 time units; bench acts 1 unit after each posedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    fl_if.alloc_ready_i = 1'b0;
    fl_if.free_valid_i  = 1'b0;
    fl_if.free_preg_i   = '0;
    fl_if.snapshot_i    = 1'b0;
    fl_if.restore_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Async reset mid-run from free_q=0x01.
  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      fl_if.alloc_ready_i = 1'b1;
      tick();
    end
    fl_if.free_valid_i = 1'b1;
    fl_if.free_preg_i  = 3'd0;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd0 || fl_if.free_count_o !== 4'd1) begin
      n_errors++;
      $display("FAIL pre_reset_state: preg=%0d cnt=%0d exp preg=0 cnt=1",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b1 || fl_if.alloc_preg_o !== 3'd7 ||
        fl_if.free_count_o !== 4'd4 || fl_if.double_free_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: valid=%0b preg=%0d cnt=%0d df=%0b exp 1 7 4 0",
               fl_if.alloc_valid_o, fl_if.alloc_preg_o, fl_if.free_count_o,
               fl_if.double_free_o);
    end
    rst = 1'b0;
  endtask

  // Five back-to-back allocation requests from reset.
  task automatic test_alloc_drain();
    logic [2:0] exp_p [4];
    exp_p = '{3'd7, 3'd6, 3'd5, 3'd4};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (fl_if.alloc_valid_o !== 1'b1 || fl_if.alloc_preg_o !== exp_p[k] ||
          fl_if.free_count_o !== 4'(4 - k)) begin
        n_errors++;
        $display("FAIL drain_grant%0d: valid=%0b preg=%0d cnt=%0d exp 1 %0d %0d",
                 k, fl_if.alloc_valid_o, fl_if.alloc_preg_o, fl_if.free_count_o,
                 exp_p[k], 4 - k);
      end
      fl_if.alloc_ready_i = 1'b1;
      tick();
    end
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b0 || fl_if.free_count_o !== 4'd0) begin
      n_errors++;
      $display("FAIL drain_empty: valid=%0b cnt=%0d exp 0 0",
               fl_if.alloc_valid_o, fl_if.free_count_o);
    end
    fl_if.alloc_ready_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b0 || fl_if.free_count_o !== 4'd0 ||
        fl_if.double_free_o !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_ignored_ready: valid=%0b cnt=%0d df=%0b exp 0 0 0",
               fl_if.alloc_valid_o, fl_if.free_count_o, fl_if.double_free_o);
    end
  endtask

  // From empty: free 2, then alloc 2 with same-cycle free 6.
  task automatic test_free_from_empty();
    fl_if.free_valid_i = 1'b1;
    fl_if.free_preg_i  = 3'd2;
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL free_no_bypass: valid=%0b exp 0", fl_if.alloc_valid_o);
    end
    tick();
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b1 || fl_if.alloc_preg_o !== 3'd2 ||
        fl_if.free_count_o !== 4'd1) begin
      n_errors++;
      $display("FAIL free_empty: valid=%0b preg=%0d cnt=%0d exp 1 2 1",
               fl_if.alloc_valid_o, fl_if.alloc_preg_o, fl_if.free_count_o);
    end
    fl_if.alloc_ready_i = 1'b1;
    fl_if.free_valid_i  = 1'b1;
    fl_if.free_preg_i   = 3'd6;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd6 || fl_if.free_count_o !== 4'd1 ||
        fl_if.double_free_o !== 1'b0) begin
      n_errors++;
      $display("FAIL alloc_and_free: preg=%0d cnt=%0d df=%0b exp 6 1 0",
               fl_if.alloc_preg_o, fl_if.free_count_o, fl_if.double_free_o);
    end
  endtask

  // Snapshot, alloc 7 and 6, restore with free 1 and ignored alloc_ready.
  task automatic test_restore();
    logic [2:0] exp_p [5];
    exp_p = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd1};
    do_reset();
    fl_if.snapshot_i = 1'b1;
    tick();
    fl_if.alloc_ready_i = 1'b1;
    tick();
    fl_if.alloc_ready_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd5 || fl_if.free_count_o !== 4'd2) begin
      n_errors++;
      $display("FAIL restore_pre: preg=%0d cnt=%0d exp 5 2",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
    fl_if.restore_i     = 1'b1;
    fl_if.free_valid_i  = 1'b1;
    fl_if.free_preg_i   = 3'd1;
    fl_if.alloc_ready_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd7 || fl_if.free_count_o !== 4'd5 ||
        fl_if.double_free_o !== 1'b0) begin
      n_errors++;
      $display("FAIL restore_post: preg=%0d cnt=%0d df=%0b exp 7 5 0",
               fl_if.alloc_preg_o, fl_if.free_count_o, fl_if.double_free_o);
    end
    // Drain to confirm the bitmap is exactly 0xF2.
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (fl_if.alloc_valid_o !== 1'b1 || fl_if.alloc_preg_o !== exp_p[k]) begin
        n_errors++;
        $display("FAIL restore_drain%0d: valid=%0b preg=%0d exp 1 %0d",
                 k, fl_if.alloc_valid_o, fl_if.alloc_preg_o, exp_p[k]);
      end
      fl_if.alloc_ready_i = 1'b1;
      tick();
    end
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL restore_drain_empty: valid=%0b exp 0", fl_if.alloc_valid_o);
    end
  endtask

  // Double free is sticky; same-cycle alloc+free of one index is not an error.
  task automatic test_double_free();
    do_reset();
    fl_if.free_valid_i = 1'b1;
    fl_if.free_preg_i  = 3'd5;
    tick();
    n_checks++;
    if (fl_if.double_free_o !== 1'b1 || fl_if.free_count_o !== 4'd4) begin
      n_errors++;
      $display("FAIL double_free_set: df=%0b cnt=%0d exp 1 4",
               fl_if.double_free_o, fl_if.free_count_o);
    end
    tick();
    tick();
    n_checks++;
    if (fl_if.double_free_o !== 1'b1) begin
      n_errors++;
      $display("FAIL double_free_sticky: df=%0b exp 1", fl_if.double_free_o);
    end
    do_reset();
    fl_if.alloc_ready_i = 1'b1;
    fl_if.free_valid_i  = 1'b1;
    fl_if.free_preg_i   = 3'd7;
    tick();
    n_checks++;
    if (fl_if.double_free_o !== 1'b0 || fl_if.alloc_preg_o !== 3'd7 ||
        fl_if.free_count_o !== 4'd4) begin
      n_errors++;
      $display("FAIL same_idx_alloc_free: df=%0b preg=%0d cnt=%0d exp 0 7 4",
               fl_if.double_free_o, fl_if.alloc_preg_o, fl_if.free_count_o);
    end
  endtask

  // Snapshot+restore together keeps the old checkpoint.
  task automatic test_snap_restore_same();
    do_reset();
    fl_if.alloc_ready_i = 1'b1;
    tick();
    fl_if.snapshot_i = 1'b1;
    fl_if.restore_i  = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd7 || fl_if.free_count_o !== 4'd4) begin
      n_errors++;
      $display("FAIL snap_restore_first: preg=%0d cnt=%0d exp 7 4",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
    fl_if.alloc_ready_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd6 || fl_if.free_count_o !== 4'd3) begin
      n_errors++;
      $display("FAIL snap_restore_alloc: preg=%0d cnt=%0d exp 6 3",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
    fl_if.restore_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd7 || fl_if.free_count_o !== 4'd4) begin
      n_errors++;
      $display("FAIL snap_restore_second: preg=%0d cnt=%0d exp 7 4",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
  endtask

  // Snapshot captures the post-allocation bitmap of its own cycle.
  task automatic test_snapshot_next_state();
    do_reset();
    fl_if.alloc_ready_i = 1'b1;
    fl_if.snapshot_i    = 1'b1;
    tick();
    fl_if.alloc_ready_i = 1'b1;
    tick();
    fl_if.restore_i = 1'b1;
    tick();
    n_checks++;
    if (fl_if.alloc_preg_o !== 3'd6 || fl_if.free_count_o !== 4'd3) begin
      n_errors++;
      $display("FAIL snapshot_next_state: preg=%0d cnt=%0d exp 6 3",
               fl_if.alloc_preg_o, fl_if.free_count_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    #12;
    n_checks++;
    if (fl_if.alloc_valid_o !== 1'b1 || fl_if.alloc_preg_o !== 3'd7 ||
        fl_if.free_count_o !== 4'd4 || fl_if.double_free_o !== 1'b0) begin
      n_errors++;
      $display("FAIL initial_reset: valid=%0b preg=%0d cnt=%0d df=%0b exp 1 7 4 0",
               fl_if.alloc_valid_o, fl_if.alloc_preg_o, fl_if.free_count_o,
               fl_if.double_free_o);
    end
    rst = 1'b0;
    tick();
    test_reset();
    test_alloc_drain();
    test_free_from_empty();
    test_restore();
    test_double_free();
    test_snap_restore_same();
    test_snapshot_next_state();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register free list for the rename stage. Holds a one-hot-per-register free bitmap.
- The bitmap is the request vector for the MSB priority encoder: the highest-index free register is offered for allocation each cycle.
- Rename consumes the allocation; commit/squash return registers.
- Supports one branch snapshot and restore for misprediction recovery.

Parameters:
- NUM_PREGS, 64, number of physical registers; power of two, >= 4.
- NUM_ARCH, 32, architectural registers; pregs 0..NUM_ARCH-1 are allocated at reset (identity map). Must be < NUM_PREGS.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- alloc_valid_o  output  1  at least one free preg exists
- alloc_preg_o  output  $clog2(NUM_PREGS)  highest-index free preg (MSB priority)
- alloc_ready_i  input  1  rename takes alloc_preg_o this cycle
- free_valid_i  input  1  return a preg to the list
- free_preg_i  input  $clog2(NUM_PREGS)  preg being returned
- snapshot_i  input  1  capture current bitmap into the checkpoint
- restore_i  input  1  reload bitmap from the checkpoint (misprediction)
- free_count_o  output  $clog2(NUM_PREGS)+1  number of free pregs
- double_free_o  output  1  sticky error: freed a preg that was already free

Behaviour:
- State: free_q[NUM_PREGS-1:0], snap_q[NUM_PREGS-1:0], double_free_q.
- Reset (async, rst_i=1):
  - free_q = bits NUM_ARCH..NUM_PREGS-1 set, all others clear; snap_q = same value; double_free_q = 0.
  - Hence alloc_valid_o=1, alloc_preg_o=NUM_PREGS-1, free_count_o=NUM_PREGS-NUM_ARCH.
- Outputs are combinational from registered state only; no input-to-output paths.
  - alloc_valid_o = |free_q.
  - alloc_preg_o = index of highest set bit of free_q; don't-care (drive 0) when alloc_valid_o=0.
  - free_count_o = popcount(free_q).
- Allocation handshake:
  - Fires when alloc_valid_o & alloc_ready_i & !restore_i. Bit alloc_preg_o clears at the next edge.
  - alloc_ready_i with alloc_valid_o=0 is ignored (no change, no error).
  - The next cycle offers the next-highest free preg; zero-latency back-to-back allocation is sustained.
- Free:
  - When free_valid_i, bit free_preg_i is set at the next edge.
  - Its effect is visible on the outputs the cycle after; it is never bypassed to alloc_preg_o in the same cycle.
  - If free_q[free_preg_i] is already 1 and no same-cycle allocation of that index occurs, set double_free_q (sticky until reset). The bitmap still ends with the bit set.
- Simultaneous alloc and free in one cycle:
  - Both apply: clear alloc index, set free index.
  - If the indices are equal (preg allocated and freed in the same cycle), the set wins: bit ends 1, no error.
- Snapshot:
  - snap_q <= next-state free_q, i.e. including this cycle's allocation and free. This captures the list exactly as the branch's successor sees it.
- Restore:
  - free_q <= snap_q | onehot(free_preg_i if free_valid_i). Frees arriving during a restore are never lost.
  - Allocation is suppressed during restore even if alloc_ready_i=1.
  - double-free is not checked in a restore cycle.
- restore_i and snapshot_i together: restore wins; snap_q is unchanged.
- Empty: alloc_valid_o=0, free_count_o=0. A free in the empty cycle makes the list non-empty on the next cycle.
- Full (all NUM_PREGS free) is legal; only reachable via frees.
- free_preg_i outside 0..NUM_PREGS-1 cannot occur (width is exact). Freeing pregs below NUM_ARCH is legal.

Test Plan:
1. NUM_PREGS=8, NUM_ARCH=4. Reset mid-run with free_q=0x01 → outputs update immediately (async): alloc_preg_o=7, alloc_valid_o=1, free_count_o=4, double_free_o=0.
2. alloc_ready_i=1 for 5 cycles from reset → grants 7,6,5,4, then alloc_valid_o=0. free_count_o goes 4,3,2,1,0. The 5th ready is ignored with the count staying 0.
3. Empty list; free preg 2 → next cycle alloc_valid_o=1, alloc_preg_o=2, free_count_o=1. Alloc and free(6) in the same cycle → next cycle alloc_preg_o=6, count=1.
4. Reset, snapshot, alloc 7 and 6, then restore with a same-cycle free of 1 → free_q=0xF2, alloc_preg_o=7, count=5. A same-cycle alloc_ready_i is not honored.
5. From reset, free preg 5 (already free) → double_free_o=1 next cycle and stays 1. Separately, alloc 7 plus same-cycle free of 7 → bit stays set, no error.
6. snapshot_i and restore_i in the same cycle after allocating 7 → free_q returns to reset snapshot 0xF0. A second restore gives 0xF0 again, proving snap_q was unchanged.
